// File: rtl/conv_pkg.sv
// Shared definitions for the convolution subsystem.
//   - Register map of the convolution core (base, control, status).
//   - Base address and depth of the convolution SRAM window.
//   - Response entry stored per slot of the SRAM response FIFO.
package conv_pkg;

  localparam logic [31:0] CONV_BASE_ADDR  = 32'h1004_0000;
  localparam logic [31:0] CONV_CTRL_ADDR  = CONV_BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] CONV_STAT_ADDR  = CONV_BASE_ADDR + 32'h0000_0004;

  localparam logic [31:0] CONV_SRAM_BASE  = 32'h1005_0000;
  localparam int unsigned CONV_SRAM_DEPTH = 4096;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_entry_t;

endpackage

// File: rtl/conv_sram_rsp_fifo.sv
// Response FIFO for conv_sram_icb.
// Synchronous FIFO of rsp_entry_t with a parameterised number of entries.
// Ports:
//   clk          - clock
//   rst_n        - synchronous active-low reset (clears pointers and count)
//   push_i       - write push_data_i into the tail slot this cycle
//   push_data_i  - entry to store
//   pop_i        - drop the head entry this cycle
//   count_o      - number of stored entries
//   head_o       - head entry (meaningful only while count_o != 0)
// The caller guarantees no push into a full FIFO and no pop from an empty one.
module conv_sram_rsp_fifo
  import conv_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PW   = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CW   = $clog2(Depth + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  rsp_entry_t    push_data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output rsp_entry_t    head_o
);

  rsp_entry_t    store_q [Depth];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) begin
      wptr_d = ptr_inc(wptr_q);
    end
    if (pop_i) begin
      rptr_d = ptr_inc(rptr_q);
    end
    // Simultaneous push and pop leave the count unchanged.
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: a slot is only observed after it was written.
  always_ff @(posedge clk) begin
    if (push_i) begin
      store_q[wptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = store_q[rptr_q];

endmodule

// File: rtl/conv_sram_icb.sv
// ICB responder giving the convolution core access to its word SRAM.
// Holds input feature maps, weights and results; serves byte-masked writes
// and word reads with strictly in-order responses.
// Ports:
//   clk, rst_n          - clock and synchronous active-low reset
//   conv_icb_cmd_*      - command channel (valid/ready, addr, read, wdata, wmask)
//   conv_icb_rsp_*      - response channel (valid/ready, rdata, err)
// Optional feature macro CONV_SRAM_ERR_EN:
//   defined   - addresses are checked against [ADDR_BASE, ADDR_BASE + 4*DEPTH_WORDS);
//               out-of-range commands do not touch the SRAM and respond with
//               conv_icb_rsp_err = 1, rdata = 0
//   undefined - no err port; addresses alias modulo the window size
module conv_sram_icb
  import conv_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = CONV_SRAM_BASE,
  parameter int unsigned DEPTH_WORDS = CONV_SRAM_DEPTH,
  parameter int unsigned RSP_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        conv_icb_cmd_valid,
  output logic        conv_icb_cmd_ready,
  input  logic [31:0] conv_icb_cmd_addr,
  input  logic        conv_icb_cmd_read,
  input  logic [31:0] conv_icb_cmd_wdata,
  input  logic [3:0]  conv_icb_cmd_wmask,
  output logic        conv_icb_rsp_valid,
  input  logic        conv_icb_rsp_ready,
`ifdef CONV_SRAM_ERR_EN
  output logic        conv_icb_rsp_err,
`endif
  output logic [31:0] conv_icb_rsp_rdata
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          cmd_accept;
  logic          rsp_pop;
  logic [CW-1:0] rsp_count;
  logic [31:0]   occupancy;
  rsp_entry_t    push_entry;
  rsp_entry_t    rsp_head;

  // Address decode
`ifdef CONV_SRAM_ERR_EN
  localparam logic [32:0] WinLo = {1'b0, ADDR_BASE};
  localparam logic [32:0] WinHi = {1'b0, ADDR_BASE} + (33'(DEPTH_WORDS) << 2);

  logic [31:0] addr_off;
  logic        unused_addr_off;

  assign addr_off        = conv_icb_cmd_addr - ADDR_BASE;
  assign in_range        = ({1'b0, conv_icb_cmd_addr} >= WinLo) &&
                           ({1'b0, conv_icb_cmd_addr} <  WinHi);
  assign word_idx        = addr_off[AW+1:2];
  assign unused_addr_off = ^{addr_off[31:AW+2], addr_off[1:0]};
`else
  logic unused_addr;
  logic unused_head_err;

  assign in_range        = 1'b1;
  // Upper address bits are ignored, so the window aliases.
  assign word_idx        = conv_icb_cmd_addr[AW+1:2];
  assign unused_addr     = ^{conv_icb_cmd_addr[31:AW+2], conv_icb_cmd_addr[1:0]};
  assign unused_head_err = rsp_head.err;
`endif

  // Flow control
  assign cmd_accept = conv_icb_cmd_valid & conv_icb_cmd_ready;
  assign rsp_pop    = conv_icb_rsp_valid & conv_icb_rsp_ready;

  // The synchronous SRAM read is captured straight into the FIFO slot, so the
  // pending stage is the slot itself and is already counted in rsp_count.
  // A pop this cycle frees a slot immediately: rsp_ready -> cmd_ready is a
  // deliberate combinational path, and cmd_valid is never involved.
  assign occupancy          = 32'(rsp_count) - 32'(rsp_pop);
  assign conv_icb_cmd_ready = occupancy < RSP_DEPTH;

  // SRAM write port; contents are not reset, and a write accepted while reset
  // is sampled low is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && cmd_accept && !conv_icb_cmd_read && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (conv_icb_cmd_wmask[b]) begin
          mem[word_idx][8*b +: 8] <= conv_icb_cmd_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response entry for the command accepted this cycle. Writes and
  // out-of-range accesses return zero data and leave the SRAM untouched.
  always_comb begin
    push_entry = '0;
    if (conv_icb_cmd_read && in_range) begin
      push_entry.rdata = mem[word_idx];
    end
    push_entry.err = ~in_range;
  end

  conv_sram_rsp_fifo #(
    .Depth (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cmd_accept),
    .push_data_i (push_entry),
    .pop_i       (rsp_pop),
    .count_o     (rsp_count),
    .head_o      (rsp_head)
  );

  // Outputs are gated by valid so that they read zero after reset and hold
  // the head entry steady while the core applies backpressure.
  assign conv_icb_rsp_valid = (rsp_count != '0);
  assign conv_icb_rsp_rdata = conv_icb_rsp_valid ? rsp_head.rdata : 32'h0;
`ifdef CONV_SRAM_ERR_EN
  assign conv_icb_rsp_err   = conv_icb_rsp_valid & rsp_head.err;
`endif

endmodule

// File: tb/tb_conv_sram_icb.sv
module tb_conv_sram_icb;

  localparam logic [31:0] BASE  = 32'h1005_0000;
  localparam int          DEPTH = 4096;
  localparam int          RSPD  = 2;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  // Reference model: word-addressed memory plus the queue of responses owed.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  bit          err_q [$];

  conv_sram_icb #(
    .ADDR_BASE   (BASE),
    .DEPTH_WORDS (DEPTH),
    .RSP_DEPTH   (RSPD)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .conv_icb_cmd_valid (cmd_valid),
    .conv_icb_cmd_ready (cmd_ready),
    .conv_icb_cmd_addr  (cmd_addr),
    .conv_icb_cmd_read  (cmd_read),
    .conv_icb_cmd_wdata (cmd_wdata),
    .conv_icb_cmd_wmask (cmd_wmask),
    .conv_icb_rsp_valid (rsp_valid),
    .conv_icb_rsp_ready (rsp_ready),
`ifdef CONV_SRAM_ERR_EN
    .conv_icb_rsp_err   (rsp_err),
`endif
    .conv_icb_rsp_rdata (rsp_rdata)
  );

`ifndef CONV_SRAM_ERR_EN
  assign rsp_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_access(input logic rd, input logic [31:0] a,
                                       input logic [31:0] wd, input logic [3:0] m);
    bit inr;
    int idx;
`ifdef CONV_SRAM_ERR_EN
    inr = ({32'd0, a} >= {32'd0, BASE}) && ({32'd0, a} < ({32'd0, BASE} + 64'(4 * DEPTH)));
    idx = int'(((a - BASE) >> 2) % DEPTH);
`else
    inr = 1'b1;
    idx = int'((a >> 2) % DEPTH);
`endif
    if (!rd && inr) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    exp_q.push_back((rd && inr) ? model_mem[idx] : 32'h0);
    err_q.push_back(!inr);
  endfunction

  // One bus cycle: drive at negedge, sample settled outputs, log an accepted
  // command into the model, then let the active edge pass.
  task automatic step(input bit v, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] m, input bit rr, output bit acc, output bit pop,
                      output logic [31:0] rdat, output logic rdy, output logic vld,
                      output logic er);
    @(negedge clk);
    cmd_valid = v;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wmask = m;
    rsp_ready = rr;
    #1;
    rdy  = cmd_ready;
    vld  = rsp_valid;
    rdat = rsp_rdata;
    er   = rsp_err;
    acc  = v && (rdy === 1'b1);
    pop  = (vld === 1'b1) && rr;
    if (acc) model_access(rd, a, wd, m);
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_byte_mask();
    bit acc, pop; logic [31:0] rd, e; logic rdy, vld, er; bit ee;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: step(1, 0, BASE + 8, 32'hA5A5_A5A5, 4'hF,    1, acc, pop, rd, rdy, vld, er);
        1: step(1, 0, BASE + 8, 32'h1234_5678, 4'b0101, 1, acc, pop, rd, rdy, vld, er);
        2: step(1, 1, BASE + 8, 32'h0,         4'h0,    1, acc, pop, rd, rdy, vld, er);
        default: step(0, 0, 32'h0, 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
      endcase
      if (k < 3) begin
        checks++;
        if (!acc) begin errors++; $display("FAIL mask_accept[%0d]: got 0 want 1", k); end
      end
      if (k == 3) begin
        checks++;
        if (vld !== 1'b1 || rd !== 32'hA534_A578) begin
          errors++; $display("FAIL mask_readback: got valid=%b data=%h want valid=1 data=a534a578", vld, rd);
        end
      end
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL mask_rsp: unexpected response %h", rd); end
        else begin
          e = exp_q.pop_front(); ee = err_q.pop_front();
          if (rd !== e || er !== ee) begin errors++; $display("FAIL mask_rsp: got %h/%b want %h/%b", rd, er, e, ee); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mask_drain: %0d responses missing", exp_q.size()); end
  endtask

  task automatic test_stream();
    bit acc, pop; logic [31:0] rd, e; logic rdy, vld, er; bit ee;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, BASE + 32'(4 * i), 32'(3 * i), 4'hF, 1, acc, pop, rd, rdy, vld, er);
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stream_wrsp: unexpected response %h", rd); end
        else begin
          e = exp_q.pop_front(); ee = err_q.pop_front();
          if (rd !== e || er !== ee) begin errors++; $display("FAIL stream_wrsp: got %h want %h", rd, e); end
        end
      end
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      step(0, 0, 32'h0, 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
      if (pop) begin
        checks++;
        e = exp_q.pop_front(); ee = err_q.pop_front();
        if (rd !== e || er !== ee) begin errors++; $display("FAIL stream_wrsp: got %h want %h", rd, e); end
      end
    end
    for (int k = 0; k < 21; k++) begin
      step(k < 16, 1, BASE + 32'(4 * k), 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
      if (k < 16) begin
        checks++;
        if (!acc) begin errors++; $display("FAIL stream_accept[%0d]: got 0 want 1", k); end
      end
      checks++;
      if (pop != (k >= 1 && k <= 16)) begin
        errors++; $display("FAIL stream_rsp_slot[%0d]: got %b want %b", k, pop, (k >= 1 && k <= 16));
      end
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stream_rdata: unexpected response %h", rd); end
        else begin
          e = exp_q.pop_front(); ee = err_q.pop_front();
          if (rd !== e || er !== ee) begin errors++; $display("FAIL stream_rdata[%0d]: got %h want %h", k, rd, e); end
        end
      end
    end
  endtask

  task automatic test_raw();
    bit acc, pop; logic [31:0] rd, e; logic rdy, vld, er; bit ee;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: step(1, 0, BASE + 4, 32'hDEAD_BEEF, 4'hF, 1, acc, pop, rd, rdy, vld, er);
        1: step(1, 1, BASE + 4, 32'h0,         4'h0, 1, acc, pop, rd, rdy, vld, er);
        default: step(0, 0, 32'h0, 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
      endcase
      if (k < 2) begin
        checks++;
        if (!acc) begin errors++; $display("FAIL raw_accept[%0d]: got 0 want 1", k); end
      end
      if (k == 2) begin
        checks++;
        if (vld !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL raw_readback: got valid=%b data=%h want valid=1 data=deadbeef", vld, rd);
        end
      end
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL raw_rsp: unexpected response %h", rd); end
        else begin
          e = exp_q.pop_front(); ee = err_q.pop_front();
          if (rd !== e || er !== ee) begin errors++; $display("FAIL raw_rsp: got %h want %h", rd, e); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc, pop; logic [31:0] rd, e, held; logic rdy, vld, er; bit ee;
    int j = 0;
    bit seen = 0;
    for (int k = 0; k < 5; k++) begin
      step(1, 1, BASE + 32'(4 * j), 32'h0, 4'h0, 0, acc, pop, rd, rdy, vld, er);
      if (acc) j++;
      if (vld === 1'b1) begin
        if (!seen) begin held = rd; seen = 1; end
        else begin
          checks++;
          if (rd !== held) begin errors++; $display("FAIL bp_stable[%0d]: got %h want %h", k, rd, held); end
        end
      end
    end
    checks++;
    if (j != RSPD) begin errors++; $display("FAIL bp_accepts: got %0d want %0d", j, RSPD); end
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready_low: got %b want 0", rdy); end
    for (int k = 0; k < 30 && (j < 5 || exp_q.size() > 0); k++) begin
      step(j < 5, 1, BASE + 32'(4 * j), 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
      if (k == 0) begin
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL bp_cmd_ready_rise: got %b want 1", rdy); end
      end
      if (acc) j++;
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_rsp: unexpected response %h", rd); end
        else begin
          e = exp_q.pop_front(); ee = err_q.pop_front();
          if (rd !== e || er !== ee) begin errors++; $display("FAIL bp_rsp: got %h want %h", rd, e); end
        end
      end
    end
    checks++;
    if (j != 5 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_complete: accepted %0d of 5, %0d responses missing", j, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit acc, pop; logic [31:0] rd; logic rdy, vld, er;
    int j = 0;
    for (int k = 0; k < 6; k++) begin
      step(j < 2, 1, BASE + 32'(4 * j), 32'h0, 4'h0, 0, acc, pop, rd, rdy, vld, er);
      if (acc) j++;
    end
    checks++;
    if (j != 2) begin errors++; $display("FAIL rmid_stall: got %0d accepts want 2", j); end
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); err_q.delete();
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 32'h0, 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
      checks++;
      if (vld !== 1'b0 || rdy !== 1'b1) begin
        errors++; $display("FAIL rmid_after[%0d]: got valid=%b ready=%b want valid=0 ready=1", k, vld, rdy);
      end
    end
  endtask

  task automatic test_out_of_range();
    bit acc, pop; logic [31:0] rd, e, prev0; logic rdy, vld, er; bit ee;
    prev0 = model_mem[0];
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: step(1, 0, BASE + 32'(4 * DEPTH), 32'h0BAD_F00D, 4'hF, 1, acc, pop, rd, rdy, vld, er);
        1: step(1, 1, BASE, 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
`ifdef CONV_SRAM_ERR_EN
        2: step(1, 1, BASE - 4, 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
`else
        2: step(1, 1, BASE + 32'(4 * DEPTH) + 4, 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
`endif
        default: step(0, 0, 32'h0, 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
      endcase
      if (k < 3) begin
        checks++;
        if (!acc) begin errors++; $display("FAIL oor_accept[%0d]: got 0 want 1", k); end
      end
`ifdef CONV_SRAM_ERR_EN
      if (k == 1) begin
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b want 1", er); end
      end
      if (k == 2) begin
        checks++;
        if (rd !== prev0 || er !== 1'b0) begin
          errors++; $display("FAIL oor_sram_unchanged: got %h/%b want %h/0", rd, er, prev0);
        end
      end
      if (k == 3) begin
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
          errors++; $display("FAIL oor_read_low: got %h/%b want 00000000/1", rd, er);
        end
      end
`else
      if (k == 2) begin
        checks++;
        if (rd !== 32'h0BAD_F00D || prev0 === 32'h0BAD_F00D) begin
          errors++; $display("FAIL alias_word0: got %h want 0badf00d", rd);
        end
      end
`endif
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL oor_rsp: unexpected response %h", rd); end
        else begin
          e = exp_q.pop_front(); ee = err_q.pop_front();
          if (rd !== e || er !== ee) begin errors++; $display("FAIL oor_rsp: got %h/%b want %h/%b", rd, er, e, ee); end
        end
      end
    end
  endtask

  task automatic test_random();
    bit acc, pop; logic [31:0] rd, e; logic rdy, vld, er; bit ee;
    bit v, rdc, rr; int n; bit exp_rdy;
    for (int k = 0; k < 300; k++) begin
      v   = ($urandom_range(0, 9) < 7);
      rdc = $urandom_range(0, 1);
      rr  = ($urandom_range(0, 9) < 6);
      n   = exp_q.size();
      step(v, rdc, BASE + 32'(4 * $urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
           rr, acc, pop, rd, rdy, vld, er);
      exp_rdy = (n - ((n > 0 && rr) ? 1 : 0)) < RSPD;
      checks++;
      if (vld !== (n > 0) || rdy !== exp_rdy) begin
        errors++; $display("FAIL rand_flow[%0d]: got valid=%b ready=%b want valid=%b ready=%b",
                           k, vld, rdy, (n > 0), exp_rdy);
      end
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_rsp: unexpected response %h", rd); end
        else begin
          e = exp_q.pop_front(); ee = err_q.pop_front();
          if (rd !== e || er !== ee) begin errors++; $display("FAIL rand_rsp[%0d]: got %h want %h", k, rd, e); end
        end
      end
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      step(0, 0, 32'h0, 32'h0, 4'h0, 1, acc, pop, rd, rdy, vld, er);
      if (pop) begin
        checks++;
        e = exp_q.pop_front(); ee = err_q.pop_front();
        if (rd !== e || er !== ee) begin errors++; $display("FAIL rand_drain: got %h want %h", rd, e); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_complete: %0d responses missing", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_byte_mask();
    test_stream();
    test_raw();
    test_backpressure();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_sram_icb.md
# conv_sram_icb

ICB responder that the convolution core reaches through its `conv_icb_*` initiator port. It holds input feature maps, weights and results in a single-port word SRAM, and serves them to the core. Byte-masked writes and in-order responses are supported. A response buffer keeps full accept throughput while the core applies response backpressure.

## Interface
- `ADDR_BASE`, default 32'h1005_0000: byte base address of the SRAM window.
- `DEPTH_WORDS`, default 4096: number of 32-bit words; power of two; AW = log2(DEPTH_WORDS).
- `RSP_DEPTH`, default 2: response buffer entries; minimum 2.
- `clk`, in, 1: the only clock.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `conv_icb_cmd_valid`, in, 1: command valid.
- `conv_icb_cmd_ready`, out, 1: command accept.
- `conv_icb_cmd_addr`, in, 32: byte address; bits [1:0] ignored.
- `conv_icb_cmd_read`, in, 1: 1 = read, 0 = write.
- `conv_icb_cmd_wdata`, in, 32: write data.
- `conv_icb_cmd_wmask`, in, 4: byte enables; bit i covers bits [8i+7:8i].
- `conv_icb_rsp_valid`, out, 1: response valid.
- `conv_icb_rsp_ready`, in, 1: response accept.
- `conv_icb_rsp_rdata`, out, 32: read data; 0 for writes.
- `conv_icb_rsp_err`, out, 1: exists only when `CONV_SRAM_ERR_EN` is defined.

## Operation
**Command accept.** A command is accepted in cycle t when `cmd_valid & cmd_ready` is high in t.

**Word index.**
- Without the macro: word index = `cmd_addr[AW+1:2]`.
- With the macro: word index = `(cmd_addr - ADDR_BASE) >> 2`.

**Writes.**
- At the end of cycle t, each byte with its `wmask` bit set is updated.
- Bytes with a clear `wmask` bit are untouched.
- `wmask` = 0 is legal: no bytes change, and a response is still returned.

**Reads.** The word is read synchronously and captured into a pending stage. The pending stage is valid in t+1.

**Response path.**
- The pending stage pushes into the response FIFO (RSP_DEPTH entries) in t+1.
- If the FIFO is empty and `rsp_ready` is high, the entry still passes through the FIFO; there is no bypass.
- `rsp_valid` = FIFO not empty.
- A pop happens when `rsp_valid & rsp_ready`.
- Responses are returned strictly in accept order.

**Flow control.**
- `cmd_ready` = (count + pending − pop) < RSP_DEPTH.
- This is a combinational path from `rsp_ready` to `cmd_ready`, and it is intended.
- `cmd_ready` never depends on `cmd_valid`.

**Read-after-write.** A read of the same word accepted in t+1 returns the data written in t.

**Backpressure.** While `rsp_valid & !rsp_ready`, `rsp_rdata` (and `rsp_err`) hold stable.

**Simultaneous events.** A push and a pop in the same cycle leave the count unchanged. A push into a full FIFO cannot occur, by construction of `cmd_ready`.

## Timing
**Reset.** While `rst_n` = 0 at a clock edge:
- FIFO count, pointers and pending are cleared.
- `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- `cmd_ready` = 1 from the first cycle after reset.
- SRAM contents are not reset.

**Reset mid-operation.** In-flight and buffered responses are discarded. A write accepted in the same cycle that reset is sampled low is dropped.

**Latency.** Minimum command-accept to `rsp_valid` is 1 cycle; `rsp_valid` rises in t+1.

**Throughput.** With `rsp_ready` held high, one command is accepted per cycle indefinitely.

**Stall recovery.** With `rsp_ready` low, at most RSP_DEPTH commands are accepted, then `cmd_ready` drops. `cmd_ready` rises again in the same cycle as the first pop.

## Configuration
Macro: `CONV_SRAM_ERR_EN`.

**Defined:**
- A command is out of range when `cmd_addr` < ADDR_BASE or `cmd_addr` ≥ ADDR_BASE + 4·DEPTH_WORDS.
- An out-of-range command gets a response with `rsp_err` = 1 and `rsp_rdata` = 0.
- An out-of-range write is dropped and no SRAM access occurs.
- The err bit is stored per FIFO entry.
- In-range responses have `rsp_err` = 0.

**Undefined:**
- Port `conv_icb_rsp_err` is absent.
- Addresses alias modulo the window size.
- Every command accesses the SRAM.

## Structure
**Shared package `conv_pkg`** holds:
- CONV_BASE_ADDR, CONV_CTRL_ADDR, CONV_STAT_ADDR.
- CONV_SRAM_BASE (= 32'h1005_0000) and CONV_SRAM_DEPTH.
- The response-entry struct {rdata[31:0], err}.

**Sub-module `conv_sram_rsp_fifo`.** Parameterised-depth synchronous FIFO providing push, pop, count, and head data.

The SRAM array, pending stage and credit logic stay in the top module.

## Test plan
1. **Byte-masked write, read back.** Write 32'hA5A5_A5A5 with `wmask` 4'hF to ADDR_BASE+8, then write 32'h1234_5678 with `wmask` 4'b0101. A subsequent read returns 32'hA534_A578, with `rsp_valid` one cycle after accept.
2. **Streaming read.** Write words i = 0..15 with data i·3, then issue back-to-back reads with `rsp_ready` held at 1. Expect 16 consecutive accepts and 16 in-order responses on consecutive cycles.
3. **Backpressure.** Hold `rsp_ready` = 0 and issue 5 reads. Exactly 2 are accepted and `cmd_ready` = 0 after that. Raise `rsp_ready`: `cmd_ready` rises the same cycle, and all 5 responses arrive in order with data stable during the stall.
4. **Read-after-write.** Write 32'hDEAD_BEEF to ADDR_BASE+4 in cycle t, then read ADDR_BASE+4 in t+1. The read returns 32'hDEAD_BEEF.
5. **Reset mid-operation.** Stall 2 reads in the FIFO, then pulse `rst_n` low for 1 cycle. Expect `rsp_valid` = 0 and `cmd_ready` = 1 afterwards, with no stale response emitted.
6. **Out-of-range access** (with `CONV_SRAM_ERR_EN`).
   - A write to ADDR_BASE+4·DEPTH_WORDS gives `rsp_err` = 1 and the SRAM is unchanged.
   - A read of ADDR_BASE−4 gives `rsp_err` = 1 and `rdata` = 0.
   - Without the macro, the same write aliases to word 0.
